// File: rtl/ble_packet_deframer.sv
// Purpose: BLE access-address correlator, de-whitener and header/payload/CRC byte framer.
// Latency: pkt_start/byte_valid/pkt_last/len_err appear 2 clks after the update rising edge that completes them.
// Backpressure: none; the bit stream is free-running and every byte is presented for exactly one clk.
module ble_packet_deframer #(
   parameter logic [31:0] ACCESS_ADDR = 32'h8E89BED6,
   parameter int unsigned MAX_ERR     = 0,
   parameter int unsigned MAX_LEN     = 37,
   parameter bit          DEWHITEN    = 1'b1,
   parameter logic [5:0]  CHANNEL     = 6'd37
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       update,
   input  logic       value,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   output logic       pkt_start,
   output logic       pkt_last,
   output logic       len_err,
   output logic [7:0] pdu_len,
   output logic       busy
);

   typedef enum logic [1:0] {
      S_SEARCH  = 2'd0,
      S_HEADER  = 2'd1,
      S_PAYLOAD = 2'd2,
      S_CRC     = 2'd3
   } state_t;

   localparam logic [5:0] MAX_ERR_W = 6'(MAX_ERR);
   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
   // Position 0 is forced to 1, positions 1..6 take the channel index MSB-first.
   localparam logic [6:0] LFSR_SEED = {CHANNEL[0], CHANNEL[1], CHANNEL[2], CHANNEL[3],
                                       CHANNEL[4], CHANNEL[5], 1'b1};

   state_t      state_q;
   logic        update_q;
   logic        evt_q;
   logic        value_q;
   logic [31:0] sr_q;
   logic [6:0]  lfsr_q;
   logic [2:0]  bit_cnt_q;
   logic [7:0]  byte_cnt_q;
   logic [7:0]  byte_q;
   logic [7:0]  byte_out_q;
   logic        byte_valid_q;
   logic        pkt_start_q;
   logic        pkt_last_q;
   logic        len_err_q;
   logic [7:0]  pdu_len_q;

   logic [31:0] sr_d;
   logic [31:0] diff;
   logic [5:0]  err_cnt;
   logic        aa_hit;
   logic [6:0]  lfsr_d;
   logic        bit_d;
   logic [7:0]  byte_d;

   // Next shift-register value, Hamming distance to the address, de-whitened bit and byte shift.
   always_comb begin
      sr_d    = {value_q, sr_q[31:1]};
      diff    = sr_d ^ ACCESS_ADDR;
      err_cnt = 6'd0;
      for (int i = 0; i < 32; i++) begin
         err_cnt = err_cnt + {5'd0, diff[i]};
      end
      aa_hit  = (err_cnt <= MAX_ERR_W);
      // pos0<-pos6, pos4<-pos3^pos6, remaining positions shift up by one.
      lfsr_d  = {lfsr_q[5], lfsr_q[4], lfsr_q[3] ^ lfsr_q[6], lfsr_q[2],
                 lfsr_q[1], lfsr_q[0], lfsr_q[6]};
      bit_d   = value_q ^ (DEWHITEN ? lfsr_q[6] : 1'b0);
      byte_d  = {bit_d, byte_q[7:1]};
   end

   // Edge detect, correlation search and packet framing FSM with registered outputs.
   // The detected edge is registered (evt_q) together with its data bit so that every
   // framing output lands a fixed 2 clks after the update rising edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_SEARCH;
         update_q     <= 1'b0;
         evt_q        <= 1'b0;
         value_q      <= 1'b0;
         sr_q         <= '0;
         lfsr_q       <= '0;
         bit_cnt_q    <= '0;
         byte_cnt_q   <= '0;
         byte_q       <= '0;
         byte_out_q   <= '0;
         byte_valid_q <= 1'b0;
         pkt_start_q  <= 1'b0;
         pkt_last_q   <= 1'b0;
         len_err_q    <= 1'b0;
         pdu_len_q    <= '0;
      end else begin
         update_q     <= update;
         evt_q        <= update & ~update_q;
         value_q      <= value;
         byte_valid_q <= 1'b0;
         pkt_start_q  <= 1'b0;
         pkt_last_q   <= 1'b0;
         len_err_q    <= 1'b0;
         if (evt_q) begin
            if (state_q == S_SEARCH) begin
               // Address bits are never whitened, so they bypass the LFSR entirely.
               sr_q <= sr_d;
               if (aa_hit) begin
                  pkt_start_q <= 1'b1;
                  lfsr_q      <= LFSR_SEED;
                  bit_cnt_q   <= '0;
                  byte_cnt_q  <= '0;
                  byte_q      <= '0;
                  state_q     <= S_HEADER;
               end
            end else begin
               lfsr_q    <= lfsr_d;
               byte_q    <= byte_d;
               bit_cnt_q <= bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  byte_out_q   <= byte_d;
                  byte_valid_q <= 1'b1;
                  byte_cnt_q   <= byte_cnt_q + 8'd1;
                  case (state_q)
                     S_HEADER: begin
                        if (byte_cnt_q != 8'd0) begin
                           pdu_len_q  <= byte_d;
                           byte_cnt_q <= '0;
                           if (byte_d > MAX_LEN_B) begin
                              len_err_q  <= 1'b1;
                              pkt_last_q <= 1'b1;
                              sr_q       <= '0;
                              state_q    <= S_SEARCH;
                           end else if (byte_d == 8'd0) begin
                              state_q <= S_CRC;
                           end else begin
                              state_q <= S_PAYLOAD;
                           end
                        end
                     end
                     S_PAYLOAD: begin
                        if (byte_cnt_q == pdu_len_q - 8'd1) begin
                           byte_cnt_q <= '0;
                           state_q    <= S_CRC;
                        end
                     end
                     S_CRC: begin
                        if (byte_cnt_q == 8'd2) begin
                           pkt_last_q <= 1'b1;
                           sr_q       <= '0;
                           state_q    <= S_SEARCH;
                        end
                     end
                     default: ;
                  endcase
               end
            end
         end
      end
   end

   assign byte_out   = byte_out_q;
   assign byte_valid = byte_valid_q;
   assign pkt_start  = pkt_start_q;
   assign pkt_last   = pkt_last_q;
   assign len_err    = len_err_q;
   assign pdu_len    = pdu_len_q;
   assign busy       = (state_q != S_SEARCH);

endmodule

// File: doc/ble_packet_deframer.md
# ble_packet_deframer

Downstream consumer of the timing-recovery/matched-filter pair: takes the recovered bit stream (`value`) and its bit-rate strobe (`update`) in the 16 MHz ADC clock domain. Correlates the stream against the 32-bit BLE access address with a configurable bit-error tolerance, optionally de-whitens, parses the PDU header length, and emits the header, payload and CRC as a framed byte stream. Its outputs feed the packet buffer and the CRC checker.

## Interface
- `ACCESS_ADDR`, 32'h8E89BED6: access address, compared in on-air (LSB-first) order.
- `MAX_ERR`, 0: maximum Hamming distance accepted for an access-address match (0–3).
- `MAX_LEN`, 37: largest legal PDU length field; larger values abort the packet.
- `DEWHITEN`, 1: 1 = apply BLE de-whitening; 0 = pass bits through.
- `CHANNEL`, 37: 6-bit channel index used to seed the whitening LFSR.
- `clk` in 1: 16 MHz SCuM ADC clock.
- `rst` in 1: asynchronous, active-low reset.
- `update` in 1: bit strobe from timing recovery; a rising edge marks a valid `value`.
- `value` in 1: recovered data bit.
- `byte_out` out 8: assembled byte, LSB = first bit received.
- `byte_valid` out 1: one-clk pulse when `byte_out` is valid.
- `pkt_start` out 1: one-clk pulse on access-address match.
- `pkt_last` out 1: high together with `byte_valid` on the final byte of a packet.
- `len_err` out 1: one-clk pulse when the length field exceeds `MAX_LEN`.
- `pdu_len` out 8: latched length field; holds until the next match.
- `busy` out 1: high in any state other than SEARCH.

## Operation
- Bit event = rising edge of `update`, taken as `update & ~update_q` with one register. A held-high `update` counts as a single event. All logic below advances only on bit events.
- Reset (`rst`=0), asynchronous: all outputs are 0, the state is SEARCH, and the shift register, counters and LFSR clear.
- SEARCH
  - Each bit shifts into a 32-bit register at the MSB, moving the contents right.
  - When popcount(reg ^ `ACCESS_ADDR`) ≤ `MAX_ERR`: pulse `pkt_start`, seed the LFSR, clear the bit/byte counters, and go to HEADER.
  - The whitening LFSR is not applied to access-address bits.
- LFSR: 7 bits, polynomial x^7+x^4+1.
  - Seed: pos0 = 1, pos1..pos6 = `CHANNEL[5:0]` MSB-first.
  - Per bit: out = pos6; data ^= out (when `DEWHITEN`); shift pos0←pos6, pos4←pos3^pos6, other positions pos[i]←pos[i-1].
- Byte assembly: de-whitened bits enter `byte_out` at bit 7 and shift right. After 8 bits, `byte_valid` pulses.
- HEADER: 2 bytes.
  - Byte 0 is emitted.
  - Byte 1 is latched into `pdu_len` and emitted.
  - If byte 1 > `MAX_LEN`: `len_err` and `pkt_last` pulse with that byte, then return to SEARCH.
  - Else go to PAYLOAD, or to CRC if the length is 0.
- PAYLOAD: emit `pdu_len` bytes, then go to CRC.
- CRC: emit 3 bytes. The third byte carries `pkt_last`, then return to SEARCH with the correlation register cleared.
- Total bytes per good packet = 5 + `pdu_len`.
- No access-address search happens while `busy`; a second address inside a packet is treated as data.

## Timing
- `update_q` edge detect adds 1 clk.
- `pkt_start`, `byte_valid`, `pkt_last` and `len_err` are registered. Each asserts exactly 1 clk after the clk in which the completing bit event is detected, i.e. 2 clks after the `update` rising edge at the input.
- `byte_out` and `pdu_len` change only in the same cycle that `byte_valid` asserts.
- Nominal bit period is 16 clks (1 Mbps). Correct behaviour is required for any bit spacing ≥ 3 clks.
- Reset asserted mid-packet aborts immediately. No `pkt_last` is produced for the aborted packet.

## Test plan
- Exact access address 0x8E89BED6, `DEWHITEN`=0, header 0x40 0x06, 6 payload bytes 0x01..0x06, CRC 0xAA 0xBB 0xCC -> one `pkt_start`, then 11 `byte_valid` pulses with bytes in order, and `pkt_last` on 0xCC only.
- Length 0 (header 0x40 0x00) -> 5 bytes, `pkt_last` on the 5th, `busy` low 1 clk after it.
- Access address with bit 5 flipped: `MAX_ERR`=0 -> no `pkt_start`, `busy` stays 0; `MAX_ERR`=1 -> `pkt_start` and normal deframing.
- Length field 0xFF with `MAX_LEN`=37 -> 2 bytes emitted, `len_err` and `pkt_last` on byte 1, back to SEARCH. A following valid packet is received correctly.
- `DEWHITEN`=1, `CHANNEL`=37, transmitted bits whitened by the bench's LFSR model -> output bytes equal the unwhitened source. Unwhitened zeros on air give a first output bit of 1.
- `rst` pulsed low for 1 clk during payload byte 3 -> all outputs 0 at once, `busy`=0, no `pkt_last`. The next packet decodes cleanly.
- `update` held high for 40 clks -> exactly one bit shifted.
